data_mem_bus: RTL and testbench

DATA_MEM_BUS -- requirements
Module: data_mem_bus

---
 rtl/data_mem_bus.sv | 132 +++++++++++++
 tb/tb_data_mem_bus.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_bus.sv
// Word-addressed data RAM behind a request/ack bus with programmable wait states and access fault detection.
// Latency WAIT_CYCLES+2 edges from accepted request to ack; requests are only sampled in IDLE (busy marks refusal).
module data_mem_bus #(
  parameter int RAM_SIZE_BIT = 5,
  parameter int WAIT_CYCLES  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        fault
);
  localparam int DEPTH = 2 ** RAM_SIZE_BIT;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic [31:0]             mem [DEPTH];
  logic [31:0]             a_addr;
  logic [31:0]             a_wdata;
  logic                    a_we;
  logic                    a_uns;
  logic [1:0]              a_size;

  logic                    bad;
  logic [RAM_SIZE_BIT-1:0] idx;
  logic [31:0]             word;
  logic [4:0]              sh;
  logic [31:0]             shifted;
  logic [31:0]             ld_val;
  logic [31:0]             mask;
  logic [31:0]             merged;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 8'h3F;  4'h1: seg7 = 8'h06;  4'h2: seg7 = 8'h5B;  4'h3: seg7 = 8'h4F;
      4'h4: seg7 = 8'h66;  4'h5: seg7 = 8'h6D;  4'h6: seg7 = 8'h7D;  4'h7: seg7 = 8'h07;
      4'h8: seg7 = 8'h7F;  4'h9: seg7 = 8'h6F;  4'hA: seg7 = 8'h77;  4'hB: seg7 = 8'h7C;
      4'hC: seg7 = 8'h39;  4'hD: seg7 = 8'h5E;  4'hE: seg7 = 8'h79;  default: seg7 = 8'h71;
    endcase
  endfunction

  always_comb begin
    bad = ((a_addr >> (RAM_SIZE_BIT + 2)) != 32'd0) ||
          (a_size == 2'b11) ||
          (a_size == 2'b01 && a_addr[0]) ||
          (a_size == 2'b10 && a_addr[1:0] != 2'b00);
    idx     = a_addr[RAM_SIZE_BIT+1:2];
    word    = mem[idx];
    sh      = {a_addr[1:0], 3'b000};
    shifted = word >> sh;
    ld_val  = word;
    mask    = 32'hFFFF_FFFF;
    case (a_size)
      2'b00: begin
        ld_val = a_uns ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        mask   = 32'h0000_00FF << sh;
      end
      2'b01: begin
        ld_val = a_uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        mask   = 32'h0000_FFFF << sh;
      end
      default: ;
    endcase
    // Shifting the full store word into place keeps only the addressed lane under the mask.
    merged = (word & ~mask) | ((a_wdata << sh) & mask);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      ack     <= 1'b0;
      busy    <= 1'b0;
      fault   <= 1'b0;
      rdata   <= 32'd0;
      a_addr  <= 32'd0;
      a_wdata <= 32'd0;
      a_we    <= 1'b0;
      a_uns   <= 1'b0;
      a_size  <= 2'b00;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= (i < 16) ? {24'h0, seg7(i[3:0])} : 32'h0;
    end else begin
      ack   <= 1'b0;
      fault <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            a_addr  <= addr;
            a_wdata <= wdata;
            a_we    <= we;
            a_uns   <= unsigned_ld;
            a_size  <= size;
            cnt     <= 4'(WAIT_CYCLES);
            state   <= WAIT;
            busy    <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= DONE;
            ack   <= 1'b1;
            fault <= bad;
            if (bad) begin
              rdata <= 32'd0;
            end else if (a_we) begin
              mem[idx] <= merged;
              rdata    <= 32'd0;
            end else begin
              rdata <= ld_val;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_bus.sv
// Bench for data_mem_bus: byte-array transaction model checked every cycle, plus directed literal vectors.
module tb_data_mem_bus;
  localparam int W  = 1;
  localparam int NB = 128;  // bytes in a 32-word RAM

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0, req2 = 1'b0;
  logic        we = 1'b0, unsigned_ld = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [31:0] rdata, rdata2;
  logic        ack, busy, fault, ack2, busy2, fault2;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  data_mem_bus #(.RAM_SIZE_BIT(5), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .unsigned_ld(unsigned_ld),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ack(ack), .busy(busy), .fault(fault));

  data_mem_bus #(.RAM_SIZE_BIT(5), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req2), .we(we), .size(size), .unsigned_ld(unsigned_ld),
    .addr(addr), .wdata(wdata), .rdata(rdata2), .ack(ack2), .busy(busy2), .fault(fault2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction model: RAM as bytes, an access occupies W+3 cycles from the accept edge.
  logic [7:0]  seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  logic [7:0]  mb [NB];
  int          left, nb;
  bit          started = 0;
  logic        m_ack, m_busy, m_fault, m_bad;
  logic [31:0] m_rdata, v;
  logic        c_we, c_uns;
  logic [1:0]  c_sz;
  logic [31:0] c_a, c_wd;

  always @(posedge clk) begin
    if (reset) begin
      started = 1;
      left = 0;
      m_ack = 0; m_busy = 0; m_fault = 0; m_rdata = 0;
      for (int i = 0; i < NB; i++) mb[i] = (i % 4 == 0 && i < 64) ? seg_tab[i / 4] : 8'h00;
    end else if (left == 0) begin
      m_ack = 0; m_fault = 0;
      if (req) begin
        c_we = we; c_uns = unsigned_ld; c_sz = size; c_a = addr; c_wd = wdata;
        left = W + 2;
        m_busy = 1;
      end else begin
        m_busy = 0;
      end
    end else begin
      left--;
      m_ack = 0; m_fault = 0;
      if (left == 1) begin
        m_bad = (c_a >= 32'(NB)) || (c_sz == 2'b11) || (c_sz == 2'b01 && c_a[0]) ||
                (c_sz == 2'b10 && c_a[1:0] != 2'b00);
        m_ack = 1;
        m_fault = m_bad;
        nb = 1 << c_sz;
        if (m_bad) begin
          m_rdata = 0;
        end else if (c_we) begin
          for (int k = 0; k < nb; k++) mb[c_a + k] = c_wd[8*k +: 8];
          m_rdata = 0;
        end else begin
          v = 0;
          for (int k = 0; k < nb; k++) v[8*k +: 8] = mb[c_a + k];
          if (!c_uns && v[8*nb-1]) for (int k = nb; k < 4; k++) v[8*k +: 8] = 8'hFF;
          m_rdata = v;
        end
      end
      m_busy = (left != 0);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("cmp_ack",   32'(ack),   32'(m_ack));
      chk("cmp_busy",  32'(busy),  32'(m_busy));
      chk("cmp_fault", 32'(fault), 32'(m_fault));
      chk("cmp_rdata", rdata, m_rdata);
    end
  end

  task automatic access(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic flt, output int lat, output int bc);
    @(negedge clk);
    req = 1; we = w; size = sz; unsigned_ld = u; addr = a; wdata = wd;
    lat = 0; bc = 0; rd = 32'd0; flt = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      req = 0;
      if (busy) bc++;
      if (ack) begin
        lat = i; rd = rdata; flt = fault;
        break;
      end
    end
    if (lat == 0) chk("access_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic run(input string name, input logic w, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_flt);
    logic [31:0] rd;
    logic        flt;
    int          lat, bc;
    access(w, sz, u, a, wd, rd, flt, lat, bc);
    chk({name, "_rdata"}, rd, exp_rd);
    chk({name, "_fault"}, 32'(flt), 32'(exp_flt));
  endtask

  initial begin
    logic [31:0] rd;
    logic        flt;
    int          lat, bc, acks, first, last, gapbad;

    repeat (2) @(negedge clk);
    reset = 0;
    chk("rst_ack",   32'(ack),   32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_rdata", rdata,      32'd0);
    chk("rst_busy0", 32'(busy2), 32'd0);

    access(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, rd, flt, lat, bc);
    chk("lw08_rdata", rd, 32'h0000_005B);
    chk("lw08_fault", 32'(flt), 32'd0);
    chk("lw08_lat", 32'(lat), 32'd3);
    chk("lw08_busy", 32'(bc), 32'd3);

    run("sw40",   1'b1, 2'b10, 1'b0, 32'h40, 32'hDEAD_BEEF, 32'h0, 1'b0);
    run("lb41",   1'b0, 2'b00, 1'b0, 32'h41, 32'h0, 32'hFFFF_FFBE, 1'b0);
    run("lbu43",  1'b0, 2'b00, 1'b1, 32'h43, 32'h0, 32'h0000_00DE, 1'b0);
    run("lh42",   1'b0, 2'b01, 1'b0, 32'h42, 32'h0, 32'hFFFF_DEAD, 1'b0);
    run("lhu40",  1'b0, 2'b01, 1'b1, 32'h40, 32'h0, 32'h0000_BEEF, 1'b0);
    run("sb45",   1'b1, 2'b00, 1'b0, 32'h45, 32'hABCD_EF12, 32'h0, 1'b0);
    run("lw44",   1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 32'h0000_1200, 1'b0);
    run("sh46",   1'b1, 2'b01, 1'b0, 32'h46, 32'h1234_5678, 32'h0, 1'b0);
    run("lw44b",  1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 32'h5678_1200, 1'b0);

    run("flt_lw42", 1'b0, 2'b10, 1'b0, 32'h42, 32'h0, 32'h0, 1'b1);
    run("flt_sw80", 1'b1, 2'b10, 1'b0, 32'h80, 32'hAAAA_AAAA, 32'h0, 1'b1);
    run("flt_sz11", 1'b1, 2'b11, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1);
    run("flt_sh41", 1'b1, 2'b01, 1'b0, 32'h41, 32'h0, 32'h0, 1'b1);
    run("keep00",   1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 32'h0000_003F, 1'b0);
    run("keep40",   1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Reset lands on the WAIT cycle of a store; the store must never complete.
    @(negedge clk);
    req = 1; we = 1; size = 2'b10; addr = 32'h44; wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    req = 0;
    chk("abort_inwait", 32'(busy), 32'd1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    acks = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    chk("abort_noack", 32'(acks), 32'd0);
    run("abort_lw44", 1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 32'h0, 1'b0);
    run("abort_lw40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0);
    run("abort_lb3c", 1'b0, 2'b00, 1'b0, 32'h3C, 32'h0, 32'h0000_0071, 1'b0);

    // Zero-wait instance with req held high: acks every third cycle.
    @(negedge clk);
    we = 0; size = 2'b10; addr = 32'h08; unsigned_ld = 0;
    req2 = 1;
    acks = 0; first = -1; last = -1; gapbad = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (ack2) begin
        if (acks == 0) first = n;
        else if (n - last != 3) gapbad++;
        last = n;
        acks++;
        chk("thru_rdata", rdata2, 32'h0000_005B);
        chk("thru_fault", 32'(fault2), 32'd0);
      end
    end
    req2 = 0;
    chk("thru_count", 32'(acks), 32'd4);
    chk("thru_first", 32'(first), 32'd2);
    chk("thru_gap", 32'(gapbad), 32'd0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
